stack_arbiter: RTL
==================

# stack_arbiter

Two-requester controller that shares one LIFO `stack` instance (pointer-based, registered `data_out`, `2**STACK_SIZE` entries) between two clients. It round-robins requests, issues at most one push or pop to the stack per cycle, and tracks occupancy so the stack is never overflowed or underflowed. Every accepted request gets a one-cycle-latency response carrying pop data or an error flag. Instantiated beside the stack; requesters never drive the stack directly.

## Interface

Parameters:
- `STACK_WIDTH`, default 18: data width. Must match the attached stack.
- `STACK_SIZE`, default 4: log2 of stack depth. Must match the attached stack. Depth `DEPTH = 2**STACK_SIZE`.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high. The same signal must drive the stack's `reset`.
- `req_valid_0`, `req_valid_1` in 1: request present.
- `req_op_0`, `req_op_1` in 1: operation. 1 = push, 0 = pop.
- `req_data_0`, `req_data_1` in STACK_WIDTH: push data.
- `req_ready_0`, `req_ready_1` out 1: grant. A request is accepted when valid and ready are both high.
- `rsp_valid_0`, `rsp_valid_1` out 1: response strobe, one cycle wide. There is no backpressure.
- `rsp_data_0`, `rsp_data_1` out STACK_WIDTH: pop data. Zero for push responses and for error responses.
- `rsp_err_0`, `rsp_err_1` out 1: the operation was refused (push when full, or pop when empty).
- `stk_push` out 1: to the stack's `push`.
- `stk_pop` out 1: to the stack's `pop`.
- `stk_data_in` out STACK_WIDTH: to the stack's `data_in`.
- `stk_data_out` in STACK_WIDTH: from the stack's `data_out`.
- `count` out STACK_SIZE+1: current occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation

Arbitration (combinational):
- Uses one register, `last_grant`.
- Only one valid requester: it is granted.
- Both valid: the requester other than `last_grant` is granted.
- At most one `req_ready_*` is high per cycle. Ready is low for a requester that is not valid.
- `last_grant` updates to the granted index on every accept.

Issue (combinational from the accept):
- `stk_push = accept & op & ~full`
- `stk_pop = accept & ~op & ~empty`
- `stk_push` and `stk_pop` are never high in the same cycle. The stack's simultaneous push/pop behaviour is unsafe and must never be exercised.
- `stk_data_in` = granted requester's `req_data`. It is zero when there is no grant.

Occupancy:
- `count` increments on `stk_push` and decrements on `stk_pop`.
- No wrap: a push at `count == DEPTH` and a pop at `count == 0` are refused and leave `count` unchanged.

Response pipeline (registered):
- On accept, register the granted index, the op, and `err` (push&full or pop&empty).
- Next cycle, assert `rsp_valid_<idx>` and `rsp_err_<idx>` from those registers.
- `rsp_data_<idx>` = `stk_data_out` when the registered op is a successful pop, else zero.
- Outputs of the non-responding requester are all zero.

Reset values:
- `count` = 0, `full` = 0, `empty` = 1.
- `last_grant` = 1, so requester 0 wins the first contention.
- Response registers cleared: all `rsp_*` outputs 0.
- `stk_push` and `stk_pop` are 0 while `reset` is high.
- `req_ready_*` are forced low while `reset` is high.

## Timing

- Throughput: one accepted request per cycle, back-to-back, alternating requesters under contention.
- Latency: accept in cycle N gives a response in cycle N+1, for all ops and for errors.
- Pop data: the stack registers `mem[ptr-1]` on the edge ending cycle N, and the controller passes it through combinationally in cycle N+1.
- Push in cycle N followed by pop in cycle N+1 must return the pushed value in cycle N+2.
- Reset asserted mid-operation: any response pending for cycle N+1 is dropped (no `rsp_valid`). `count` returns to 0 along with the stack pointer.
- Requester protocol: a requester holds `valid`, `op` and `data` stable until accepted. The controller holds no request state before acceptance.

## Test plan

- Reset, then requester 0 pushes 0x00011, 0x00022, 0x00033 on consecutive cycles, then pops 3 times. Required: pushes respond err=0 at +1 cycle, pops return 0x00033, 0x00022, 0x00011 at +1 cycle, `count` goes 0→3→0, `empty`=1 at end.
- Both requesters hold push requests (R0 data 0xA, R1 data 0xB) for 4 cycles. Required: grants alternate R0, R1, R0, R1; `count`=4; a pop from R1 returns 0xB.
- Push 16 values with STACK_SIZE=4. Required: `full`=1 and `count`=16. A 17th push gives `rsp_err`=1, `stk_push` stays 0, and a following pop returns the 16th value.
- Pop on empty after reset. Required: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, `stk_pop` never asserted, `count` stays 0.
- R0 push 0x3FFFF and R1 pop in the same cycle with R1 favoured by `last_grant`. Required: R1's pop errs (empty), then R0's push is accepted next cycle. A later R1 pop returns 0x3FFFF.
- Push 5 values, assert `reset` for 1 cycle in the cycle after a pop acceptance. Required: no response for that pop, `count`=0, and a subsequent pop errs.

Source files
------------

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
//
// Shares one pointer-based LIFO stack between two requesters. Requests are
// round-robined, at most one push or pop reaches the stack per cycle, and an
// occupancy counter refuses pushes when full and pops when empty so the stack
// is never overflowed or underflowed. Every accepted request gets a response
// exactly one cycle later carrying pop data or an error flag.
//
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high
//                                reset (also drives the stack's reset)
//   req_valid_*/req_op_*/
//   req_data_*                 - request from requester 0/1 (op 1 = push)
//   req_ready_*                - grant; accept = valid & ready
//   rsp_valid_*/rsp_data_*/
//   rsp_err_*                  - one-cycle response strobe, pop data, refusal
//   stk_push/stk_pop/
//   stk_data_in                - drive the attached stack
//   stk_data_out               - registered data output of the stack
//   count/full/empty           - current stack occupancy
// ---------------------------------------------------------------------------
module stack_arbiter #(
  parameter int STACK_WIDTH = 18,
  parameter int STACK_SIZE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_0,
  input  logic                   req_op_0,
  input  logic [STACK_WIDTH-1:0] req_data_0,
  input  logic                   req_valid_1,
  input  logic                   req_op_1,
  input  logic [STACK_WIDTH-1:0] req_data_1,
  output logic                   req_ready_0,
  output logic                   req_ready_1,
  output logic                   rsp_valid_0,
  output logic [STACK_WIDTH-1:0] rsp_data_0,
  output logic                   rsp_err_0,
  output logic                   rsp_valid_1,
  output logic [STACK_WIDTH-1:0] rsp_data_1,
  output logic                   rsp_err_1,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [STACK_WIDTH-1:0] stk_data_in,
  input  logic [STACK_WIDTH-1:0] stk_data_out,
  output logic [STACK_SIZE:0]    count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [STACK_SIZE:0] FULL_COUNT = {1'b1, {STACK_SIZE{1'b0}}};
  localparam logic [STACK_SIZE:0] ONE_COUNT  = {{STACK_SIZE{1'b0}}, 1'b1};

  logic last_grant;
  logic grant_0;
  logic grant_1;
  logic accept;
  logic grant_idx;
  logic grant_op;
  logic grant_err;

  logic rsp_pend;
  logic rsp_idx;
  logic rsp_op;
  logic rsp_err_r;
  logic rsp_pop_ok;

  // Round-robin arbitration: a lone requester always wins; under contention
  // the requester that was not granted last time wins. Nothing is granted
  // while reset is high so the stack sees no traffic during reset.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset) begin
      if (req_valid_0 && req_valid_1) begin
        if (last_grant) grant_0 = 1'b1;
        else            grant_1 = 1'b1;
      end else if (req_valid_0) begin
        grant_0 = 1'b1;
      end else if (req_valid_1) begin
        grant_1 = 1'b1;
      end
    end
  end

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;
  assign accept      = grant_0 | grant_1;
  assign grant_idx   = grant_1;
  assign grant_op    = grant_1 ? req_op_1 : req_op_0;

  // Refused operations still get accepted and answered, they just never
  // reach the stack; push and pop are mutually exclusive because only one
  // request is granted per cycle.
  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign grant_err   = grant_op ? full : empty;
  assign stk_push    = accept &  grant_op & ~full;
  assign stk_pop     = accept & ~grant_op & ~empty;
  assign stk_data_in = grant_1 ? req_data_1 : (grant_0 ? req_data_0 : '0);

  // Occupancy tracks the stack pointer exactly; it resets together with the
  // stack so the two can never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (stk_push) begin
      count <= count + ONE_COUNT;
    end else if (stk_pop) begin
      count <= count - ONE_COUNT;
    end
  end

  // Remember who was served last; reset to 1 so requester 0 wins the first
  // contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

  // Response pipeline: capture who was served, what they asked for and
  // whether it was refused, so the answer can be presented next cycle when
  // the stack's registered data_out holds the popped word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pend  <= 1'b0;
      rsp_idx   <= 1'b0;
      rsp_op    <= 1'b0;
      rsp_err_r <= 1'b0;
    end else begin
      rsp_pend  <= accept;
      rsp_idx   <= grant_idx;
      rsp_op    <= grant_op;
      rsp_err_r <= accept & grant_err;
    end
  end

  // Responses are masked by reset so a response already registered when
  // reset arrives mid-operation is dropped rather than presented.
  assign rsp_pop_ok  = ~rsp_op & ~rsp_err_r;
  assign rsp_valid_0 = rsp_pend & ~reset & ~rsp_idx;
  assign rsp_valid_1 = rsp_pend & ~reset &  rsp_idx;
  assign rsp_err_0   = rsp_valid_0 & rsp_err_r;
  assign rsp_err_1   = rsp_valid_1 & rsp_err_r;
  assign rsp_data_0  = (rsp_valid_0 && rsp_pop_ok) ? stk_data_out : '0;
  assign rsp_data_1  = (rsp_valid_1 && rsp_pop_ok) ? stk_data_out : '0;

endmodule
